vec_read_arbiter: RTL and testbench

Shares a single AXI-stream vector reader among NUM_REQ requesters. Each requester posts a read request with a vector length. A round-robin scheduler grants one request at a time, sequences the reader's start/ready protocol, captures the resulting vector and returns it to the granted requester with a done pulse. It sits between the puzzle-solver cores and the one axi_read_vector instance on the input stream.

---
 rtl/vec_read_pkg.sv | 16 +
 rtl/vec_read_arbiter_if.sv | 35 +++
 rtl/rr_pick.sv | 34 +++
 rtl/vec_read_arbiter.sv | 131 +++++++++++++
 tb/tb_vec_read_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/vec_read_pkg.sv
// Shared types and helpers for the vector-reader arbiter and the reader it fronts.
package vec_read_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } arb_state_t;

  // Width of a length field able to hold 0..max_len inclusive.
  function automatic int len_width(input int max_len);
    return (max_len <= 1) ? 1 : $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/vec_read_arbiter_if.sv
// Bundle of requester-side and reader-side signals around the arbiter.
// slave: the arbiter itself; master: the requesters and the shared reader.
interface vec_read_arbiter_if
  import vec_read_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int MAX_VEC_LENGTH = 64
);
  localparam int MAX_VEC_LENGTH_W = len_width(MAX_VEC_LENGTH);

  // Requester side
  logic [NUM_REQ-1:0]                       req;
  logic [NUM_REQ-1:0][MAX_VEC_LENGTH_W-1:0] req_len;
  logic [NUM_REQ-1:0]                       done;
  logic [NUM_REQ-1:0]                       err;
  logic [MAX_VEC_LENGTH-1:0]                vec_out;
  logic                                     busy;

  // Reader side
  logic                                     rd_start;
  logic [MAX_VEC_LENGTH_W-1:0]              rd_vec_length;
  logic                                     rd_ready;
  logic [MAX_VEC_LENGTH-1:0]                rd_vec;

  modport slave (
    input  req, req_len, rd_ready, rd_vec,
    output done, err, vec_out, busy, rd_start, rd_vec_length
  );

  modport master (
    output req, req_len, rd_ready, rd_vec,
    input  done, err, vec_out, busy, rd_start, rd_vec_length
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr,
// wrapping past NUM_REQ-1 back to 0.
module rr_pick #(
  parameter int NUM_REQ  = 4,
  parameter int REQ_ID_W = (NUM_REQ <= 1) ? 1 : $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [REQ_ID_W-1:0] rr_ptr,
  output logic                any,
  output logic [REQ_ID_W-1:0] idx
);

  // Scan offsets from farthest to nearest so the nearest hit to rr_ptr wins.
  always_comb begin
    logic [REQ_ID_W:0]   sum;
    logic [REQ_ID_W-1:0] pos;
    any = 1'b0;
    idx = '0;
    sum = '0;
    pos = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      sum = {1'b0, rr_ptr} + (REQ_ID_W + 1)'(off);
      if (sum >= (REQ_ID_W + 1)'(NUM_REQ)) begin
        sum = sum - (REQ_ID_W + 1)'(NUM_REQ);
      end
      pos = sum[REQ_ID_W-1:0];
      if (req[pos]) begin
        any = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/vec_read_arbiter.sv
// Round-robin arbiter sharing one AXI-stream vector reader among NUM_REQ
// requesters. One transfer in flight at a time; the captured vector is
// returned on vec_out with a one-cycle done pulse to the granted requester.
module vec_read_arbiter
  import vec_read_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int MAX_VEC_LENGTH   = 64,
  parameter int MAX_VEC_LENGTH_W = len_width(MAX_VEC_LENGTH),
  parameter int REQ_ID_W         = (NUM_REQ <= 1) ? 1 : $clog2(NUM_REQ)
) (
  input logic                clk,
  input logic                rst,
  vec_read_arbiter_if.slave  bus
);

  arb_state_t                  state_q;
  arb_state_t                  state_d;
  logic [REQ_ID_W-1:0]         rr_ptr;
  logic [REQ_ID_W-1:0]         gnt_id;
  logic [MAX_VEC_LENGTH_W-1:0] len_q;
  logic [MAX_VEC_LENGTH-1:0]   vec_q;
  logic [NUM_REQ-1:0]          done_q;
  logic [NUM_REQ-1:0]          err_q;
  logic                        rd_start_q;
  logic                        busy_q;

  logic                        pick_any;
  logic [REQ_ID_W-1:0]         pick_idx;
  logic [MAX_VEC_LENGTH_W-1:0] pick_len;
  logic                        len_bad;
  logic                        len_zero;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [REQ_ID_W-1:0] id);
    logic [NUM_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  function automatic logic [REQ_ID_W-1:0] next_id(input logic [REQ_ID_W-1:0] id);
    if (int'(id) == NUM_REQ - 1) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

  rr_pick #(
    .NUM_REQ  (NUM_REQ),
    .REQ_ID_W (REQ_ID_W)
  ) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  assign pick_len = bus.req_len[pick_idx];
  assign len_bad  = (pick_len > MAX_VEC_LENGTH_W'(MAX_VEC_LENGTH));
  assign len_zero = (pick_len == '0);

  // Next-state selection for the grant/issue/wait/deliver sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_any && !len_bad) begin
          state_d = len_zero ? DELIVER : ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.rd_ready) state_d = DELIVER;
      DELIVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, grant bookkeeping, capture and registered pulse outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr     <= '0;
      gnt_id     <= '0;
      len_q      <= '0;
      vec_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      rd_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d != IDLE);
      rd_start_q <= (state_d == ISSUE);
      done_q     <= '0;
      err_q      <= '0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            gnt_id <= pick_idx;
            len_q  <= pick_len;
            if (len_bad) begin
              // Rejected requests still advance the pointer so others get a turn.
              err_q  <= onehot(pick_idx);
              rr_ptr <= next_id(pick_idx);
            end else if (len_zero) begin
              vec_q  <= '0;
              done_q <= onehot(pick_idx);
            end
          end
        end
        WAIT: begin
          if (bus.rd_ready) begin
            vec_q  <= bus.rd_vec;
            done_q <= onehot(gnt_id);
          end
        end
        DELIVER: rr_ptr <= next_id(gnt_id);
        default: ;
      endcase
    end
  end

  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.vec_out       = vec_q;
  assign bus.busy          = busy_q;
  assign bus.rd_start      = rd_start_q;
  // The length is only presented while the reader is being driven.
  assign bus.rd_vec_length = (state_q == ISSUE || state_q == WAIT) ? len_q : '0;

endmodule

// File: tb/tb_vec_read_arbiter.sv
// Directed bench for vec_read_arbiter with a behavioural stand-in for the reader.
module tb_vec_read_arbiter;

  logic clk;
  logic rst;

  vec_read_arbiter_if #(.NUM_REQ(4), .MAX_VEC_LENGTH(64)) bus ();

  vec_read_arbiter #(.NUM_REQ(4), .MAX_VEC_LENGTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          errors = 0;
  int          checks = 0;

  // Reader model controls and observations
  int          rd_delay  = 2;
  bit          use_tag   = 1'b0;
  logic [63:0] vec_base  = '0;
  int          start_cnt = 0;
  logic [6:0]  last_len  = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reader model: on rd_start, wait rd_delay cycles then pulse rd_ready once.
  initial begin
    bit aborted;
    bus.rd_ready = 1'b0;
    bus.rd_vec   = '0;
    forever begin
      @(negedge clk);
      if (!rst && bus.rd_start) begin
        start_cnt++;
        last_len = bus.rd_vec_length;
        aborted  = 1'b0;
        for (int i = 0; i < rd_delay && !aborted; i++) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
        end
        if (!aborted) begin
          bus.rd_vec   = use_tag ? (vec_base ^ 64'(last_len)) : vec_base;
          bus.rd_ready = 1'b1;
          @(negedge clk);
          bus.rd_ready = 1'b0;
        end
      end
    end
  end

  // Advance to the first negedge showing done or err; cyc=-1 if none within budget.
  task automatic wait_event(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.done != '0 || bus.err != '0) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL reset_done got=%b want=0000", bus.done); end
    checks++; if (bus.err !== 4'b0000) begin errors++; $display("FAIL reset_err got=%b want=0000", bus.err); end
    checks++; if (bus.rd_start !== 1'b0) begin errors++; $display("FAIL reset_rd_start got=%b want=0", bus.rd_start); end
    checks++; if (bus.rd_vec_length !== 7'd0) begin errors++; $display("FAIL reset_rd_len got=%0d want=0", bus.rd_vec_length); end
    checks++; if (bus.vec_out !== 64'd0) begin errors++; $display("FAIL reset_vec_out got=%h want=0", bus.vec_out); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_round_robin();
    int         cyc;
    int         id;
    logic [6:0] lens [4];
    logic [3:0] exp_done;
    lens = '{7'd8, 7'd16, 7'd24, 7'd32};
    for (int i = 0; i < 4; i++) bus.req_len[i] = lens[i];
    rd_delay = 2;
    use_tag  = 1'b1;
    vec_base = 64'h1111_2222_3333_4444;
    bus.req  = 4'hF;
    for (int k = 0; k < 5; k++) begin
      id       = k % 4;
      exp_done = 4'b0001 << id;
      wait_event(cyc);
      checks++; if (cyc < 0) begin errors++; $display("FAIL rr_timeout k=%0d got=no event want=done", k); end
      checks++; if (bus.done !== exp_done) begin errors++; $display("FAIL rr_done k=%0d got=%b want=%b", k, bus.done, exp_done); end
      checks++; if (bus.err !== 4'b0000) begin errors++; $display("FAIL rr_err k=%0d got=%b want=0000", k, bus.err); end
      checks++; if (last_len !== lens[id]) begin errors++; $display("FAIL rr_rd_len k=%0d got=%0d want=%0d", k, last_len, lens[id]); end
      checks++; if (bus.vec_out !== (vec_base ^ 64'(lens[id]))) begin errors++; $display("FAIL rr_vec k=%0d got=%h want=%h", k, bus.vec_out, vec_base ^ 64'(lens[id])); end
    end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_single();
    int cyc;
    int s0;
    bus.req_len[2] = 7'd40;
    rd_delay = 5;
    use_tag  = 1'b0;
    vec_base = 64'hDEADBEEF_12345678;
    s0       = start_cnt;
    bus.req  = 4'b0100;
    @(negedge clk);
    checks++; if (bus.rd_start !== 1'b1) begin errors++; $display("FAIL single_rd_start got=%b want=1", bus.rd_start); end
    checks++; if (bus.rd_vec_length !== 7'd40) begin errors++; $display("FAIL single_rd_len got=%0d want=40", bus.rd_vec_length); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b want=1", bus.busy); end
    @(negedge clk);
    checks++; if (bus.rd_start !== 1'b0) begin errors++; $display("FAIL single_rd_start_1cyc got=%b want=0", bus.rd_start); end
    checks++; if (bus.rd_vec_length !== 7'd40) begin errors++; $display("FAIL single_rd_len_hold got=%0d want=40", bus.rd_vec_length); end
    wait_event(cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL single_latency got=%0d want=5", cyc); end
    checks++; if (bus.done !== 4'b0100) begin errors++; $display("FAIL single_done got=%b want=0100", bus.done); end
    checks++; if (bus.vec_out !== 64'hDEADBEEF_12345678) begin errors++; $display("FAIL single_vec got=%h want=deadbeef12345678", bus.vec_out); end
    bus.req = 4'b0000;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL single_done_pulse got=%b want=0000", bus.done); end
    checks++; if (bus.vec_out !== 64'hDEADBEEF_12345678) begin errors++; $display("FAIL single_vec_hold got=%h want=deadbeef12345678", bus.vec_out); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL single_starts got=%0d want=1", start_cnt - s0); end
  endtask

  // Pointer sits at 3 after serving requester 2, so 0 must beat 1.
  task automatic test_wrap();
    int cyc;
    bus.req_len[0] = 7'd8;
    bus.req_len[1] = 7'd12;
    rd_delay = 1;
    use_tag  = 1'b1;
    vec_base = 64'h0F0F_0F0F_0F0F_0F0F;
    bus.req  = 4'b0011;
    wait_event(cyc);
    checks++; if (bus.done !== 4'b0001) begin errors++; $display("FAIL wrap_first got=%b want=0001", bus.done); end
    bus.req = 4'b0010;
    wait_event(cyc);
    checks++; if (bus.done !== 4'b0010) begin errors++; $display("FAIL wrap_second got=%b want=0010", bus.done); end
    checks++; if (bus.vec_out !== (64'h0F0F_0F0F_0F0F_0F0F ^ 64'd12)) begin errors++; $display("FAIL wrap_vec got=%h want=%h", bus.vec_out, 64'h0F0F_0F0F_0F0F_0F0F ^ 64'd12); end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    int s0;
    s0             = start_cnt;
    bus.req_len[0] = 7'd0;
    bus.req        = 4'b0001;
    @(negedge clk);
    checks++; if (bus.done !== 4'b0001) begin errors++; $display("FAIL zero_done got=%b want=0001", bus.done); end
    checks++; if (bus.vec_out !== 64'd0) begin errors++; $display("FAIL zero_vec got=%h want=0", bus.vec_out); end
    checks++; if (bus.rd_start !== 1'b0) begin errors++; $display("FAIL zero_rd_start got=%b want=0", bus.rd_start); end
    bus.req = 4'b0000;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after got=%b want=0", bus.busy); end
    checks++; if (start_cnt !== s0) begin errors++; $display("FAIL zero_starts got=%0d want=%0d", start_cnt, s0); end
  endtask

  task automatic test_err();
    int cyc;
    int s0;
    s0             = start_cnt;
    bus.req_len[1] = 7'd65;
    bus.req_len[2] = 7'd20;
    rd_delay = 2;
    use_tag  = 1'b1;
    vec_base = 64'h1234_5678_9ABC_DEF0;
    bus.req  = 4'b0110;
    @(negedge clk);
    checks++; if (bus.err !== 4'b0010) begin errors++; $display("FAIL err_pulse got=%b want=0010", bus.err); end
    checks++; if (bus.done !== 4'b0000) begin errors++; $display("FAIL err_no_done got=%b want=0000", bus.done); end
    checks++; if (bus.rd_start !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL err_idle got=start%b/busy%b want=0/0", bus.rd_start, bus.busy); end
    bus.req = 4'b0100;
    @(negedge clk);
    checks++; if (bus.err !== 4'b0000) begin errors++; $display("FAIL err_one_cycle got=%b want=0000", bus.err); end
    checks++; if (bus.rd_start !== 1'b1 || bus.rd_vec_length !== 7'd20) begin errors++; $display("FAIL err_next_issue got=start%b/len%0d want=1/20", bus.rd_start, bus.rd_vec_length); end
    wait_event(cyc);
    checks++; if (bus.done !== 4'b0100) begin errors++; $display("FAIL err_next_done got=%b want=0100", bus.done); end
    checks++; if (start_cnt - s0 !== 1) begin errors++; $display("FAIL err_starts got=%0d want=1", start_cnt - s0); end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    int cyc;
    bus.req_len[3] = 7'd16;
    rd_delay = 30;
    use_tag  = 1'b1;
    vec_base = 64'hCAFE_0000_BEEF_0000;
    bus.req  = 4'b1000;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.rd_vec_length !== 7'd16) begin errors++; $display("FAIL rstmid_wait got=busy%b/len%0d want=1/16", bus.busy, bus.rd_vec_length); end
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b want=0", bus.busy); end
    checks++; if (bus.rd_vec_length !== 7'd0) begin errors++; $display("FAIL rstmid_rd_len got=%0d want=0", bus.rd_vec_length); end
    checks++; if (bus.vec_out !== 64'd0) begin errors++; $display("FAIL rstmid_vec got=%h want=0", bus.vec_out); end
    checks++; if (bus.rd_start !== 1'b0 || bus.done !== 4'b0000 || bus.err !== 4'b0000) begin errors++; $display("FAIL rstmid_pulses got=%b/%b/%b want=0/0000/0000", bus.rd_start, bus.done, bus.err); end
    repeat (2) @(negedge clk);
    rd_delay = 3;
    rst      = 1'b0;
    wait_event(cyc);
    checks++; if (bus.done !== 4'b1000) begin errors++; $display("FAIL rstmid_done got=%b want=1000", bus.done); end
    checks++; if (bus.vec_out !== (64'hCAFE_0000_BEEF_0000 ^ 64'd16)) begin errors++; $display("FAIL rstmid_vec_after got=%h want=%h", bus.vec_out, 64'hCAFE_0000_BEEF_0000 ^ 64'd16); end
    bus.req = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    bus.req     = '0;
    bus.req_len = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_round_robin();
    test_single();
    test_wrap();
    test_zero_len();
    test_err();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
